// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit: FSM states,
// ALU operation codes, RV32I opcode/funct fields and the instruction decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WB,
    TRAP
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic       legal;
    logic [2:0] alu;
  } dec_t;

  function automatic logic [2:0] f3_alu(input logic [2:0] f3);
    case (f3)
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_XOR:  return ALU_XOR;
      F3_SRL:  return ALU_SRL;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // Legality check plus ALU operation for a full instruction word.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ir[14:12];
    f7 = ir[31:25];
    d.legal = 1'b0;
    d.alu   = ALU_ADD;
    case (ir[6:0])
      OP_R: begin
        if (f7 == F7_ZERO) begin
          d.legal = (f3 != F3_SLTU);
          d.alu   = f3_alu(f3);
        end else if (f7 == F7_SUB && f3 == F3_ADD_SUB) begin
          d.legal = 1'b1;
          d.alu   = ALU_SUB;
        end
      end
      OP_I: begin
        d.alu = f3_alu(f3);
        case (f3)
          F3_SLL, F3_SRL: d.legal = (f7 == F7_ZERO);
          F3_SLTU:        d.legal = 1'b0;
          default:        d.legal = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: d.legal = (f3 == F3_WORD);
      OP_BRANCH: begin
        d.legal = (f3 == F3_BEQ) || (f3 == F3_BNE);
        d.alu   = ALU_SUB;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-fetch and data-memory handshake between the control unit
// (master) and the memories (slave).
interface multicycle_ctrl_if #(
  parameter int WORD = 32
);
  logic            instr_req;
  logic            imem_valid;
  logic [WORD-1:0] instr;
  logic            memRead;
  logic            memWrite;
  logic            mem_ready;

  modport master (
    output instr_req, memRead, memWrite,
    input  imem_valid, instr, mem_ready
  );

  modport slave (
    input  instr_req, memRead, memWrite,
    output imem_valid, instr, mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_imm_gen.sv
// Combinational immediate generator: sign-extended I, S or B immediate
// selected by opcode; zero for formats without an immediate.
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic [WORD-1:0] instr,
  output logic [WORD-1:0] imm
);

  // rs1/funct3 bits never feed an immediate in the supported formats
  logic unused_fields;
  assign unused_fields = ^instr[19:12];

  // Format select and sign extension from bit 31
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_I, OP_LOAD: imm = {{(WORD-12){instr[31]}}, instr[31:20]};
      OP_STORE:      imm = {{(WORD-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:     imm = {{(WORD-13){instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
      default:       imm = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB).
// Every output is a register loaded at the edge that leaves the state
// which computes it, so strobes appear one cycle after their state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int WORD             = 32,
  parameter int REG_SIZE         = 5,
  parameter int ALU_CONTROL_SIZE = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_ctrl_if.master           bus,
  input  logic                        zero,
  output logic                        pcWrite,
  output logic                        branchTaken,
  output logic                        regWrite,
  output logic                        aluSrcImm,
  output logic [REG_SIZE-1:0]         rs1,
  output logic [REG_SIZE-1:0]         rs2,
  output logic [REG_SIZE-1:0]         rd,
  output logic [ALU_CONTROL_SIZE-1:0] ALUControl,
  output logic [WORD-1:0]             imm,
  output logic                        illegal
);

  state_t                      state, state_d;
  logic [WORD-1:0]             ir, ir_d, imm_w, imm_d;
  logic                        req_d, mrd_d, mwr_d, pcw_d, bt_d, rw_d, src_d, ill_d;
  logic [REG_SIZE-1:0]         rs1_d, rs2_d, rd_d;
  logic [ALU_CONTROL_SIZE-1:0] alu_d;
  logic [6:0]                  opcode;
  dec_t                        dec;

  imm_gen #(.WORD(WORD)) u_imm_gen (
    .instr (ir),
    .imm   (imm_w)
  );

  // Next state and next value of every registered output
  always_comb begin
    state_d = state;
    ir_d    = ir;
    req_d   = 1'b0;
    mrd_d   = 1'b0;
    mwr_d   = 1'b0;
    pcw_d   = 1'b0;
    bt_d    = 1'b0;
    rw_d    = 1'b0;
    src_d   = aluSrcImm;
    rs1_d   = rs1;
    rs2_d   = rs2;
    rd_d    = rd;
    imm_d   = imm;
    alu_d   = ALUControl;
    ill_d   = illegal;
    opcode  = ir[6:0];
    dec     = decode(ir);
    case (state)
      FETCH: begin
        if (bus.imem_valid) begin
          ir_d    = bus.instr;
          state_d = DECODE;
        end else begin
          req_d = 1'b1;
        end
      end
      DECODE: begin
        rs1_d = ir[19:15];
        rs2_d = ir[24:20];
        rd_d  = ir[11:7];
        imm_d = imm_w;
        src_d = (opcode == OP_I) || (opcode == OP_LOAD) || (opcode == OP_STORE);
        // ALUControl is loaded here so it is stable throughout EXECUTE
        alu_d = dec.alu;
        if (dec.legal) begin
          state_d = EXECUTE;
        end else begin
          ill_d   = 1'b1;
          state_d = TRAP;
        end
      end
      EXECUTE: begin
        case (opcode)
          OP_LOAD: begin
            mrd_d   = 1'b1;
            state_d = MEM;
          end
          OP_STORE: begin
            mwr_d   = 1'b1;
            state_d = MEM;
          end
          OP_BRANCH: begin
            pcw_d   = 1'b1;
            bt_d    = (ir[14:12] == F3_BNE) ? !zero : zero;
            state_d = FETCH;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        if (bus.mem_ready) begin
          if (opcode == OP_LOAD) begin
            state_d = WB;
          end else begin
            pcw_d   = 1'b1;
            state_d = FETCH;
          end
        end else begin
          mrd_d = (opcode == OP_LOAD);
          mwr_d = (opcode == OP_STORE);
        end
      end
      WB: begin
        rw_d    = (rd != '0);
        pcw_d   = 1'b1;
        state_d = FETCH;
      end
      TRAP: ill_d = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  // State, instruction register and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= FETCH;
      ir            <= '0;
      bus.instr_req <= 1'b0;
      bus.memRead   <= 1'b0;
      bus.memWrite  <= 1'b0;
      pcWrite       <= 1'b0;
      branchTaken   <= 1'b0;
      regWrite      <= 1'b0;
      aluSrcImm     <= 1'b0;
      rs1           <= '0;
      rs2           <= '0;
      rd            <= '0;
      ALUControl    <= '0;
      imm           <= '0;
      illegal       <= 1'b0;
    end else begin
      state         <= state_d;
      ir            <= ir_d;
      bus.instr_req <= req_d;
      bus.memRead   <= mrd_d;
      bus.memWrite  <= mwr_d;
      pcWrite       <= pcw_d;
      branchTaken   <= bt_d;
      regWrite      <= rw_d;
      aluSrcImm     <= src_d;
      rs1           <= rs1_d;
      rs2           <= rs2_d;
      rd            <= rd_d;
      ALUControl    <= alu_d;
      imm           <= imm_d;
      illegal       <= ill_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a scoreboard of expected retirements.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        zero = 1'b0;
  logic        pcWrite, branchTaken, regWrite, aluSrcImm, illegal;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  ALUControl;
  logic [31:0] imm;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int          lat;
    logic [2:0]  alu;
    logic        rw;
    logic        bt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        src;
    int          mrd;
    int          mwr;
    logic        has_imm;
    logic        has_rs2;
  } exp_t;

  exp_t sb[$];

  multicycle_ctrl_if #(.WORD(32)) bus ();

  multicycle_ctrl #(.WORD(32), .REG_SIZE(5), .ALU_CONTROL_SIZE(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .zero        (zero),
    .pcWrite     (pcWrite),
    .branchTaken (branchTaken),
    .regWrite    (regWrite),
    .aluSrcImm   (aluSrcImm),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .ALUControl  (ALUControl),
    .imm         (imm),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(int lat, logic [2:0] alu, logic rw, logic bt,
                              logic [4:0] r1, logic [4:0] r2, logic [4:0] rdv,
                              logic [31:0] iv, logic src, int mrd, int mwr,
                              logic has_imm, logic has_rs2);
    exp_t e;
    e.lat = lat; e.alu = alu; e.rw = rw; e.bt = bt;
    e.rs1 = r1; e.rs2 = r2; e.rd = rdv; e.imm = iv; e.src = src;
    e.mrd = mrd; e.mwr = mwr; e.has_imm = has_imm; e.has_rs2 = has_rs2;
    return e;
  endfunction

  // Cycle-level invariants while out of reset
  always @(negedge clk) begin
    if (reset) begin
      chk("inv/rw_and_mw", {31'b0, regWrite & bus.memWrite}, 32'd0);
      chk("inv/pc_in_trap", {31'b0, illegal & pcWrite}, 32'd0);
    end
  end

  // Issue one instruction, then pop its expectation when pcWrite appears
  task automatic run(input string tag, input logic [31:0] w, input logic z,
                     input int mem_wait, input exp_t e);
    exp_t got;
    int   rw_cnt = 0, mrd_cnt = 0, mwr_cnt = 0, req = 0;
    logic done = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    bus.instr      = w;
    bus.imem_valid = 1'b1;
    bus.mem_ready  = 1'b0;
    zero           = z;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    bus.instr      = '0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk({tag, "/alu"}, {29'b0, ALUControl}, {29'b0, sb[0].alu});
        chk({tag, "/rs1"}, {27'b0, rs1}, {27'b0, sb[0].rs1});
        chk({tag, "/rd"}, {27'b0, rd}, {27'b0, sb[0].rd});
        chk({tag, "/src"}, {31'b0, aluSrcImm}, {31'b0, sb[0].src});
        if (sb[0].has_rs2) chk({tag, "/rs2"}, {27'b0, rs2}, {27'b0, sb[0].rs2});
        if (sb[0].has_imm) chk({tag, "/imm"}, imm, sb[0].imm);
      end
      mrd_cnt += int'(bus.memRead);
      mwr_cnt += int'(bus.memWrite);
      rw_cnt  += int'(regWrite);
      if (bus.memRead || bus.memWrite) begin
        req++;
        bus.mem_ready = (req > mem_wait);
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (pcWrite) begin
        got  = sb.pop_front();
        done = 1'b1;
        chk({tag, "/latency"}, cyc, got.lat);
        chk({tag, "/branchTaken"}, {31'b0, branchTaken}, {31'b0, got.bt});
        chk({tag, "/regWrite_at_pc"}, {31'b0, regWrite}, {31'b0, got.rw});
        chk({tag, "/rd_at_pc"}, {27'b0, rd}, {27'b0, got.rd});
      end
    end
    chk({tag, "/retired"}, {31'b0, done}, 32'd1);
    @(negedge clk);
    rw_cnt += int'(regWrite);
    chk({tag, "/pc_single_pulse"}, {31'b0, pcWrite}, 32'd0);
    chk({tag, "/regWrite_cycles"}, rw_cnt, e.rw ? 32'd1 : 32'd0);
    chk({tag, "/memRead_cycles"}, mrd_cnt, e.mrd);
    chk({tag, "/memWrite_cycles"}, mwr_cnt, e.mwr);
  endtask

  // One-edge reset from the current negedge, then confirm FETCH restarts
  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    bus.imem_valid = 1'b0;
    bus.mem_ready  = 1'b0;
    @(negedge clk);
    chk({tag, "/illegal"}, {31'b0, illegal}, 32'd0);
    chk({tag, "/strobes"}, {27'b0, pcWrite, regWrite, bus.memWrite, bus.memRead, bus.instr_req}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk({tag, "/instr_req"}, {31'b0, bus.instr_req}, 32'd1);
  endtask

  task automatic trap(input string tag, input logic [31:0] w);
    @(negedge clk);
    bus.instr      = w;
    bus.imem_valid = 1'b1;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      chk({tag, "/illegal"}, {31'b0, illegal}, 32'd1);
      chk({tag, "/no_strobes"}, {27'b0, pcWrite, regWrite, bus.memWrite, bus.memRead, bus.instr_req}, 32'd0);
    end
    reset_pulse({tag, "/reset"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    bus.imem_valid = 1'b0;
    bus.instr      = '0;
    bus.mem_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset/strobes", {27'b0, pcWrite, regWrite, bus.memWrite, bus.memRead, bus.instr_req}, 32'd0);
    chk("reset/illegal", {31'b0, illegal}, 32'd0);
    chk("reset/alu_rd", {24'b0, ALUControl, rd}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset/instr_req", {31'b0, bus.instr_req}, 32'd1);

    //                     lat alu      rw bt rs1 rs2 rd imm src mrd mwr himm hrs2
    run("add",  32'h002081B3, 1'b0, 0, mk(3, ALU_ADD, 1, 0, 1, 2, 3, 0, 0, 0, 0, 0, 1));
    run("sub",  32'h402081B3, 1'b0, 0, mk(3, ALU_SUB, 1, 0, 1, 2, 3, 0, 0, 0, 0, 0, 1));
    run("or",   32'h0020E1B3, 1'b0, 0, mk(3, ALU_OR,  1, 0, 1, 2, 3, 0, 0, 0, 0, 0, 1));
    run("addi", 32'h00700293, 1'b0, 0, mk(3, ALU_ADD, 1, 0, 0, 0, 5, 7, 1, 0, 0, 1, 0));
    run("addi_x0", 32'h00700013, 1'b0, 0, mk(3, ALU_ADD, 0, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0));
    run("lw",   32'h0040A303, 1'b0, 3, mk(7, ALU_ADD, 1, 0, 1, 0, 6, 4, 1, 4, 0, 1, 0));
    run("sw",   32'h0020A423, 1'b0, 0, mk(3, ALU_ADD, 0, 0, 1, 2, 8, 8, 1, 0, 1, 1, 1));
    run("beq_z1", 32'h00208463, 1'b1, 0, mk(2, ALU_SUB, 0, 1, 1, 2, 8, 8, 0, 0, 0, 1, 1));
    run("beq_z0", 32'h00208463, 1'b0, 0, mk(2, ALU_SUB, 0, 0, 1, 2, 8, 8, 0, 0, 0, 1, 1));
    run("bne_z1", 32'h00209463, 1'b1, 0, mk(2, ALU_SUB, 0, 0, 1, 2, 8, 8, 0, 0, 0, 1, 1));
    run("bne_z0", 32'h00209463, 1'b0, 0, mk(2, ALU_SUB, 0, 1, 1, 2, 8, 8, 0, 0, 0, 1, 1));

    trap("illegal_ones", 32'hFFFFFFFF);

    // Store stalled in MEM, then reset while memWrite is up
    @(negedge clk);
    bus.instr      = 32'h0020A423;
    bus.imem_valid = 1'b1;
    bus.mem_ready  = 1'b0;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 10 && !seen; cyc++) begin
      @(negedge clk);
      seen = bus.memWrite;
    end
    chk("mid_mem/memWrite_seen", {31'b0, seen}, 32'd1);
    reset_pulse("mid_mem");

    trap("srai_reject", 32'h4010D293);

    chk("scoreboard/empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
